// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with parity, stop-bit count, framing-error
// detection, false-start rejection and a 2-flop input synchroniser.
// Optional build macro UART_RX_MAJORITY_EN: each bit decision becomes a 2-of-3 vote of
// the samples at mid-1, mid and mid+1 (one clock of extra latency).
module uart_rx_cfg #(
  parameter int unsigned clksPerBit = 87,
  parameter int unsigned dataBits   = 8,
  parameter int unsigned parityMode = 1,
  parameter int unsigned stopBits   = 1
) (
  input  logic                i_clk,
  input  logic                i_rstN,
  input  logic                i_rxBit,
  output logic                o_rxValid,
  output logic [dataBits-1:0] o_rxBits,
  output logic                o_parityError,
  output logic                o_frameError,
  output logic                o_busy
);

  localparam int unsigned CNT_W = $clog2(clksPerBit);
  localparam int unsigned BIT_W = $clog2(dataBits + 1);
  localparam int unsigned MID   = (clksPerBit - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned VOTE_LAT = 1;
`else
  localparam int unsigned VOTE_LAT = 0;
`endif
  // Start decision point; later decisions follow every clksPerBit clocks.
  localparam int unsigned START_PT = MID + VOTE_LAT;
  localparam int unsigned LAST_PT  = clksPerBit - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                sync1_q, sync2_q;
  logic                line;
  logic                bit_val;
  logic                tick_start, tick_bit;
  logic                par_calc;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [dataBits-1:0] shift_q, shift_d;
  logic                par_err_q, par_err_d;
  logic                frm_err_q, frm_err_d;
  logic                armed_q, armed_d;
  logic                rx_valid_q, rx_valid_d;
  logic [dataBits-1:0] rx_bits_q, rx_bits_d;
  logic                par_q, par_d;
  logic                frm_q, frm_d;
  logic                busy_q, busy_d;

  // Two-flop synchroniser, preset to the idle (high) line level.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_rxBit;
      sync2_q <= sync1_q;
    end
  end

  assign line = sync2_q;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  // Two-deep history of the synchronised line for the 2-of-3 vote.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) hist_q <= 2'b11;
    else         hist_q <= {hist_q[0], line};
  end

  assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & line) | (hist_q[0] & line);
`else
  assign bit_val = line;
`endif

  assign tick_start = (cnt_q == CNT_W'(START_PT));
  assign tick_bit   = (cnt_q == CNT_W'(LAST_PT));
  assign par_calc   = ^{shift_q, bit_val};

  // State register.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!line && armed_q) state_d = S_START;
      S_START:  if (tick_start) state_d = bit_val ? S_IDLE : S_DATA;
      S_DATA:   if (tick_bit && (bit_cnt_q == BIT_W'(dataBits - 1)))
                  state_d = (parityMode != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (tick_bit) state_d = S_STOP;
      S_STOP:   if (tick_bit && (bit_cnt_q == BIT_W'(stopBits - 1))) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath updates and registered-output next values.
  always_comb begin
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    armed_d    = armed_q;
    rx_valid_d = 1'b0;
    rx_bits_d  = rx_bits_q;
    par_d      = par_q;
    frm_d      = frm_q;
    case (state_q)
      S_IDLE: begin
        cnt_d     = (state_d == S_START) ? CNT_W'(1) : '0;
        bit_cnt_d = '0;
        par_err_d = 1'b0;
        frm_err_d = 1'b0;
        armed_d   = armed_q | line;
      end
      S_START: begin
        cnt_d = tick_start ? '0 : cnt_q + CNT_W'(1);
      end
      S_DATA: begin
        if (tick_bit) begin
          cnt_d     = '0;
          shift_d   = {bit_val, shift_q[dataBits-1:1]};
          bit_cnt_d = (bit_cnt_q == BIT_W'(dataBits - 1)) ? '0 : bit_cnt_q + BIT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (tick_bit) begin
          cnt_d     = '0;
          par_err_d = (parityMode == 2) ? ~par_calc : par_calc;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (tick_bit) begin
          cnt_d     = '0;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (!bit_val) frm_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        // A line still low here (break) must return high before the next frame.
        armed_d   = line;
      end
      default: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
      end
    endcase
    if (state_q == S_STOP && state_d == S_DONE) begin
      rx_valid_d = 1'b1;
      rx_bits_d  = shift_q;
      par_d      = (parityMode != 0) ? par_err_q : 1'b0;
      frm_d      = frm_err_q | ~bit_val;
    end
    busy_d = !(state_d inside {S_IDLE, S_DONE});
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      armed_q    <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_bits_q  <= '0;
      par_q      <= 1'b0;
      frm_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      armed_q    <= armed_d;
      rx_valid_q <= rx_valid_d;
      rx_bits_q  <= rx_bits_d;
      par_q      <= par_d;
      frm_q      <= frm_d;
      busy_q     <= busy_d;
    end
  end

  assign o_rxValid     = rx_valid_q;
  assign o_rxBits      = rx_bits_q;
  assign o_parityError = par_q;
  assign o_frameError  = frm_q;
  assign o_busy        = busy_q;

endmodule
